spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: frame width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for sp_clk, ss and mosi; legal range 2..4.
REQ-003 clk  input  1  system clock; all logic on posedge clk; one clock only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sp_clk  input  1  SPI clock from master; asynchronous to clk, treated as data.
REQ-006 ss  input  1  slave select, active-low.
REQ-007 mosi  input  1  serial data from master, MSB first.
REQ-008 miso  output  1  serial data to master, MSB first.
REQ-009 tx_data  input  WIDTH  next word to transmit.
REQ-010 tx_valid / tx_ready  input / output  1  write handshake into the one-entry tx holding register.
REQ-011 rx_data  output  WIDTH  last received word.
REQ-012 rx_valid / rx_ready  output / input  1  read handshake for rx_data.
REQ-013 busy_s  output  1  high while a frame is in progress.

Function
REQ-014 sp_clk, ss and mosi SHALL each pass through SYNC_STAGES flops; an edge SHALL be detected by comparing the last synchronised stage with one extra registered copy.
REQ-015 The FSM SHALL have states IDLE and SHIFT: IDLE->SHIFT on synchronised ss falling; SHIFT->IDLE on synchronised ss rising; any other input SHALL leave the state unchanged.
REQ-016 On entry to SHIFT, bit counter SHALL clear to 0, and the tx shift register SHALL load from the holding register if it is full (holding register empties), else all zeros; miso SHALL present shift-register MSB in the same cycle.
REQ-017 On each detected sp_clk falling edge in SHIFT, synchronised mosi SHALL shift into the rx shift register LSB and the bit counter SHALL increment.
REQ-018 On each detected sp_clk rising edge in SHIFT, except the first after entry to SHIFT, the tx shift register SHALL shift left by one, zero-filled, and miso SHALL follow the new MSB.
REQ-019 When the counter reaches WIDTH on a falling edge, it SHALL wrap to 0, rx_data SHALL update and rx_valid SHALL assert on the next clk, and the tx shift register SHALL reload per REQ-016, giving back-to-back multi-word frames.
REQ-020 rx_valid SHALL stay high until a clk edge with rx_ready=1; if a new word completes on that same edge, rx_valid SHALL remain high with the new data.
REQ-021 tx_ready SHALL be high when the holding register is empty; a write with tx_valid & tx_ready SHALL fill it; a simultaneous write and reload SHALL move the old word to the shift register and store the new word.
REQ-022 ss deasserting mid-word SHALL discard the partial word without asserting rx_valid, clear the counter, and drive miso 0; the holding register SHALL be kept.
REQ-023 busy_s SHALL equal (state == SHIFT); in IDLE miso SHALL be 0.
REQ-024 Latency: pin edge to internal action SHALL be SYNC_STAGES+1 clk; sp_clk half-period SHALL exceed SYNC_STAGES+2 clk periods, otherwise behaviour is undefined.

Reset
REQ-025 While rst is high on a clk edge: state=IDLE, counter=0, all shift, sync and holding registers 0, miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy_s=0; reset SHALL take priority over every other event, including mid-frame.

Configuration
REQ-026 With SPI_SLAVE_OVERRUN_EN defined, the block SHALL add output rx_overrun (1 bit). It SHALL set for one clk when a word completes while rx_valid=1 and rx_ready=0; the new word SHALL overwrite rx_data.
REQ-027 Without SPI_SLAVE_OVERRUN_EN, the port SHALL be absent and the overwrite SHALL occur silently.

Structure
REQ-028 Package spi_pkg SHALL hold the FSM state enum (IDLE, SHIFT), the default WIDTH constant and the default SYNC_STAGES constant.
REQ-029 The synchroniser plus edge detector SHALL be sub-module spi_sync_edge (ports: clk, rst, d_in, q, rise, fall), instantiated once for sp_clk and once for ss; mosi SHALL use a plain synchroniser.

Verification
REQ-030 tx holds 8'hA5, ss low, 8 sp_clk cycles with mosi=8'h3C -> rx_data=8'h3C, rx_valid 1, master samples 8'hA5.
REQ-031 Two back-to-back words (8'h01, 8'hFF) without ss release, rx_ready=1 -> two rx_valid pulses, data in order.
REQ-032 ss released after 5 bits -> no rx_valid, busy_s falls, counter 0; next full frame received correctly.
REQ-033 rx_ready=0 across two words (OVERRUN_EN) -> rx_overrun pulses once, rx_data = second word.
REQ-034 rst asserted mid-word -> all outputs at reset values next clk; tx_ready=1.
REQ-035 No tx write before frame -> master receives 8'h00; tx_valid during reload edge -> old word sent, new word held, tx_ready=0.

Source files
------------

// File: rtl/spi_slave_rx_pkg.sv
// Shared types and defaults for the SPI slave receiver (package spi_pkg).
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Word-level handshake bundle between the SPI slave and its local user.
interface spi_slave_rx_if #(
    parameter int WIDTH = spi_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_rx_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus rise/fall detection.
// STAGES must be at least 2.
module spi_sync_edge #(
    parameter int STAGES = spi_pkg::DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the pin through the chain; keep one delayed copy of the last stage.
    // NOTE: combinational blocks use blocking '=' with a default for every
    // output; registers are only written with '<=' in always_ff.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and delay registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge flags come from comparing the settled level with its delayed copy.
    always_comb begin
        q    = sync_q[STAGES-1];
        rise = q & ~prev_q;
        fall = ~q & prev_q;
    end
endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave: mosi sampled on sp_clk falling, miso launched on sp_clk rising
// (first rising of each word skipped because the MSB is presented on load).
// Optional feature: define SPI_SLAVE_OVERRUN_EN to add the rx_overrun output.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sp_clk,
    input  logic ss,
    input  logic mosi,
    output logic miso,
    output logic busy_s,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic rx_overrun,
`endif
    spi_slave_rx_if.slave bus
);
    localparam int                CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic unused_levels;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst(rst), .d_in(sp_clk),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk(clk), .rst(rst), .d_in(ss),
        .q(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    assign unused_levels = sclk_s ^ ss_s;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic                   skip_q, skip_d;
    logic                   hold_full_q, hold_full_d;
    logic [WIDTH-1:0]       hold_data_q, hold_data_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;

    logic mosi_s, entry, leave, in_shift, word_done, reload, tx_ready, tx_write;

    // State register plus all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mosi_sync_q <= '0;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            skip_q      <= 1'b0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mosi_sync_q <= mosi_sync_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            skip_q      <= skip_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next state: slave select alone moves the FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = SHIFT;
            SHIFT:   if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift, count, tx holding register and rx handshake updates.
    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];

        entry     = (state_q == IDLE) && ss_fall;
        leave     = (state_q == SHIFT) && ss_rise;
        in_shift  = (state_q == SHIFT) && !ss_rise;
        word_done = in_shift && sclk_fall && (cnt_q == LAST);
        reload    = entry || word_done;
        // A reload frees the holding slot this cycle, so a new word may land.
        tx_ready  = !hold_full_q || reload;
        tx_write  = bus.tx_valid && tx_ready;

        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        skip_d      = skip_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        rx_data_d   = rx_data_q;

        if (in_shift && sclk_fall) begin
            rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
            if (cnt_q == LAST) begin
                cnt_d     = '0;
                rx_data_d = rx_shift_d;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (leave || entry) begin
            cnt_d      = '0;
            rx_shift_d = '0;
        end

        if (reload) begin
            tx_shift_d = hold_full_q ? hold_data_q : '0;
            skip_d     = 1'b1;
        end else if (in_shift && sclk_rise) begin
            if (skip_q) skip_d = 1'b0;
            else        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        end else if (leave) begin
            tx_shift_d = '0;
            skip_d     = 1'b0;
        end

        if (reload && hold_full_q) hold_full_d = 1'b0;
        if (tx_write) begin
            hold_full_d = 1'b1;
            hold_data_d = bus.tx_data;
        end

        rx_valid_d = word_done || (rx_valid_q && !bus.rx_ready);
        overrun_d  = word_done && rx_valid_q && !bus.rx_ready;
    end

    // Outputs: miso only drives while a frame is in progress.
    always_comb begin
        busy_s       = (state_q == SHIFT);
        miso         = busy_s ? tx_shift_q[WIDTH-1] : 1'b0;
        bus.tx_ready = tx_ready;
        bus.rx_data  = rx_data_q;
        bus.rx_valid = rx_valid_q;
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    assign rx_overrun = overrun_q;
`else
    logic unused_overrun;
    assign unused_overrun = overrun_q;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx (default WIDTH=8, SYNC_STAGES=2).
module tb_spi_slave_rx;
    localparam int HALF = 8;   // sp_clk half period in clk cycles

    logic clk, rst, sp_clk, ss, mosi, miso, busy_s;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_overrun;
`endif
    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;
    logic [7:0] rx_q[$];

    spi_slave_rx_if #(.WIDTH(8)) bus_if ();

    spi_slave_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sp_clk(sp_clk), .ss(ss), .mosi(mosi),
        .miso(miso), .busy_s(busy_s),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_overrun(rx_overrun),
`endif
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted rx word and count overrun pulses.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus_if.rx_valid && bus_if.rx_ready) rx_q.push_back(bus_if.rx_data);
`ifdef SPI_SLAVE_OVERRUN_EN
            if (rx_overrun) ovr_cnt++;
`endif
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic s);
        sp_clk = 1'b1;
        mosi   = b;
        tick(HALF);
        s      = miso;
        sp_clk = 1'b0;
        tick(HALF);
    endtask

    task automatic spi_word(input logic [7:0] w, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(w[i], b);
            r[i] = b;
        end
    endtask

    task automatic ss_begin();
        ss = 1'b0;
        tick(HALF);
    endtask

    task automatic ss_end();
        ss = 1'b1;
        tick(HALF);
    endtask

    task automatic tx_push(input logic [7:0] d);
        int n = 0;
        bus_if.tx_data  = d;
        bus_if.tx_valid = 1'b1;
        while (!bus_if.tx_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!bus_if.tx_ready) begin
            tests++;
            fails++;
            $display("FAIL tx_push_timeout: tx_ready stayed %0b, wanted 1", bus_if.tx_ready);
        end
        tick(1);
        bus_if.tx_valid = 1'b0;
    endtask

    task automatic rx_pop();
        bus_if.rx_ready = 1'b1;
        tick(1);
        bus_if.rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] mosi_w;
        logic [7:0] tx_w;
        logic       tx_en;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    initial begin
        vec_t       vecs[4];
        logic [7:0] r, r2;
        logic [7:0] mw[3];
        logic [7:0] exp_tx[$];
        logic [7:0] exp_m;
        int         base, nw, ovr_base;
        logic       dummy;

        vecs[0] = '{8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5};
        vecs[1] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'h5A, 1'b1, 8'hFF, 8'h5A};
        vecs[3] = '{8'h81, 8'h00, 1'b0, 8'h81, 8'h00};

        rst = 1'b1; sp_clk = 1'b0; ss = 1'b1; mosi = 1'b0;
        bus_if.tx_data = '0; bus_if.tx_valid = 1'b0; bus_if.rx_ready = 1'b0;
        tick(3);
        check("reset_miso", miso, 0);
        check("reset_busy", busy_s, 0);
        check("reset_rx_valid", bus_if.rx_valid, 0);
        check("reset_rx_data", bus_if.rx_data, 0);
        check("reset_tx_ready", bus_if.tx_ready, 1);
        rst = 1'b0;
        tick(6);

        // Single-word frames from the vector table.
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].tx_en) tx_push(vecs[v].tx_w);
            ss_begin();
            check("vec_busy", busy_s, 1);
            spi_word(vecs[v].mosi_w, r);
            ss_end();
            check("vec_rx_valid", bus_if.rx_valid, 1);
            check("vec_rx_data", bus_if.rx_data, vecs[v].exp_rx);
            check("vec_miso_word", r, vecs[v].exp_miso);
            check("vec_idle_miso", miso, 0);
            rx_pop();
            check("vec_rx_cleared", bus_if.rx_valid, 0);
        end

        // Back-to-back words, consumer always ready.
        bus_if.rx_ready = 1'b1;
        base = rx_q.size();
        ss_begin();
        spi_word(8'h01, r);
        spi_word(8'hFF, r);
        ss_end();
        check("b2b_count", rx_q.size() - base, 2);
        if (rx_q.size() - base == 2) begin
            check("b2b_word0", rx_q[base], 8'h01);
            check("b2b_word1", rx_q[base+1], 8'hFF);
        end
        bus_if.rx_ready = 1'b0;

        // Abort after 5 bits; the holding register must survive the abort.
        tx_push(8'hE7);
        ss_begin();
        for (int i = 0; i < 2; i++) spi_bit(1'b1, dummy);
        tx_push(8'h18);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, dummy);
        ss_end();
        check("abort_rx_valid", bus_if.rx_valid, 0);
        check("abort_busy", busy_s, 0);
        check("abort_miso", miso, 0);
        check("abort_hold_kept", bus_if.tx_ready, 0);
        ss_begin();
        spi_word(8'hC5, r);
        ss_end();
        check("after_abort_rx", bus_if.rx_data, 8'hC5);
        check("after_abort_valid", bus_if.rx_valid, 1);
        check("after_abort_miso", r, 8'h18);
        rx_pop();

        // Two words with no read in between: second overwrites the first.
        ovr_base = ovr_cnt;
        ss_begin();
        spi_word(8'h11, r);
        spi_word(8'h22, r);
        ss_end();
        check("overwrite_data", bus_if.rx_data, 8'h22);
        check("overwrite_valid", bus_if.rx_valid, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("overrun_pulses", ovr_cnt - ovr_base, 1);
`endif
        rx_pop();

        // Write arriving on the reload edge: old word sent, new word held.
        tx_push(8'h96);
        fork
            tx_push(8'hC3);
            begin
                ss_begin();
                check("reload_write_tx_ready", bus_if.tx_ready, 0);
                spi_word(8'h00, r);
                spi_word(8'h00, r2);
                ss_end();
            end
        join
        check("reload_old_word", r, 8'h96);
        check("reload_new_word", r2, 8'hC3);
        check("reload_drained", bus_if.tx_ready, 1);
        rx_pop();

        // Reset in the middle of a word.
        tx_push(8'h77);
        ss_begin();
        spi_word(8'h5A, r);
        tx_push(8'h66);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, dummy);
        check("pre_reset_valid", bus_if.rx_valid, 1);
        rst = 1'b1;
        tick(1);
        check("midrst_busy", busy_s, 0);
        check("midrst_rx_valid", bus_if.rx_valid, 0);
        check("midrst_rx_data", bus_if.rx_data, 0);
        check("midrst_tx_ready", bus_if.tx_ready, 1);
        check("midrst_miso", miso, 0);
        ss = 1'b1; sp_clk = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(6);
        ss_begin();
        spi_word(8'h3C, r);
        ss_end();
        check("post_rst_rx", bus_if.rx_data, 8'h3C);
        check("post_rst_miso", r, 8'h00);
        rx_pop();

        // Randomised frames against a word-level model.
        bus_if.rx_ready = 1'b1;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                base = rx_q.size();
                ss_begin();
                for (int i = 0; i < int'($urandom_range(1, 7)); i++) spi_bit($urandom_range(0, 1) == 1, dummy);
                ss_end();
                check("rand_abort_none", rx_q.size() - base, 0);
            end
            nw = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                exp_tx.push_back(8'($urandom));
                tx_push(exp_tx[$]);
            end
            base = rx_q.size();
            ss_begin();
            for (int w = 0; w < nw; w++) begin
                mw[w] = 8'($urandom);
                spi_word(mw[w], r);
                exp_m = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'h00;
                check("rand_miso", r, exp_m);
            end
            ss_end();
            check("rand_count", rx_q.size() - base, nw);
            for (int w = 0; w < nw; w++)
                if (base + w < rx_q.size()) check("rand_rx", rx_q[base+w], mw[w]);
        end
        bus_if.rx_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
